ex_mul_seq: RTL and testbench

Iterative multiply sequencer for the EX stage. It takes over ALU op `4'b1011` (multiply) from the single-cycle ALU and computes the product with a radix-2 shift-add loop, one bit per cycle. While the loop runs it holds the front of the pipeline with a stall signal. It sits beside the EX ALU: EX selects `EX_mul_out` instead of the ALU result when `EX_mul_valid` is high.

---
 rtl/ex_pkg.sv | 19 +
 rtl/ex_mul_dp.sv | 45 ++++
 rtl/ex_mul_seq.sv | 52 +++++
 tb/tb_ex_mul_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: EX-stage ALU opcodes and multiply-sequencer state encoding
package ex_pkg;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OP_AND  = 4'b0010;
  localparam logic [3:0] ALU_OP_OR   = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0101;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
  localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLT  = 4'b1000;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1001;
  localparam logic [3:0] ALU_OP_LUI  = 4'b1010;
  localparam logic [3:0] ALU_OP_MUL  = 4'b1011;
  typedef enum logic [1:0] {MUL_IDLE = 2'd0, MUL_RUN = 2'd1, MUL_DONE = 2'd2} mul_state_e;
  function automatic logic is_mul(input logic [3:0] op);
    return op == ALU_OP_MUL;
  endfunction
endpackage

// File: rtl/ex_mul_dp.sv
// ex_mul_dp: shift-add multiply datapath; MUL_EARLY_EXIT_EN makes last fire when the multiplier runs out of set bits
module ex_mul_dp #(
  parameter int XLEN = 32,
  localparam int CW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            clear,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc,
  output logic            last
);
  logic [XLEN-1:0] mcand, mplier;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (clear) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc + (mplier[0] ? mcand : '0);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
`ifdef MUL_EARLY_EXIT_EN
  assign last = mplier[XLEN-1:1] == '0;
`else
  assign last = cnt == CW'(XLEN - 1);
`endif
endmodule

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative EX-stage multiply sequencer with pipeline stall; MUL_EARLY_EXIT_EN shortens runs for small multipliers
module ex_mul_seq import ex_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_valid,
  input  logic [3:0]      EX_alu_op,
  input  logic            EX_brn,
  input  logic [XLEN-1:0] EX_a,
  input  logic [XLEN-1:0] EX_b,
  input  logic            EX_flush,
  output logic            EX_stall,
  output logic            EX_mul_valid,
  output logic [XLEN-1:0] EX_mul_out,
  output logic            mul_busy
);
  mul_state_e state, state_nxt;
  logic start, load, step, clear, last, zero_b;
  assign start = EX_valid & ~EX_brn & is_mul(EX_alu_op) & ~EX_flush;
  assign load  = state == MUL_IDLE & start;
  assign step  = state == MUL_RUN & ~EX_flush;
  assign clear = state == MUL_RUN & EX_flush;
`ifdef MUL_EARLY_EXIT_EN
  assign zero_b = EX_b == '0;
`else
  assign zero_b = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= MUL_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = MUL_IDLE;
    if (load) state_nxt = zero_b ? MUL_DONE : MUL_RUN;
    else if (step) state_nxt = last ? MUL_DONE : MUL_RUN;
  end
  // stall only while a start is accepted or the loop is live, and never under reset
  assign EX_stall     = rst_n & (load | step);
  assign EX_mul_valid = state == MUL_DONE & ~EX_flush;
  assign mul_busy     = state != MUL_IDLE;
  ex_mul_dp #(.XLEN(XLEN)) u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .clear (clear),
    .a     (EX_a),
    .b     (EX_b),
    .acc   (EX_mul_out),
    .last  (last)
  );
endmodule

// File: tb/tb_ex_mul_seq.sv
// tb_ex_mul_seq: table, hand-written and random checks of ex_mul_seq against a plain-arithmetic model
module tb_ex_mul_seq;
  localparam int XLEN = 32;
  localparam logic [3:0] OP_MUL = 4'b1011;
  localparam logic [3:0] OP_ADD = 4'b0000;
  logic clk = 0, rst_n = 0, EX_valid = 0, EX_brn = 0, EX_flush = 0;
  logic [3:0] EX_alu_op = '0;
  logic [XLEN-1:0] EX_a = '0, EX_b = '0;
  logic EX_stall, EX_mul_valid, mul_busy;
  logic [XLEN-1:0] EX_mul_out;
  int passed = 0, total = 0;
  typedef struct {logic [XLEN-1:0] a, b, p;} vec_t;
  always #5 clk = ~clk;
  ex_mul_seq #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .EX_valid     (EX_valid),
    .EX_alu_op    (EX_alu_op),
    .EX_brn       (EX_brn),
    .EX_a         (EX_a),
    .EX_b         (EX_b),
    .EX_flush     (EX_flush),
    .EX_stall     (EX_stall),
    .EX_mul_valid (EX_mul_valid),
    .EX_mul_out   (EX_mul_out),
    .mul_busy     (mul_busy)
  );
  function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] f;
    f = (2*XLEN)'(a) * (2*XLEN)'(b);
    return f[XLEN-1:0];
  endfunction
  // cycles from the start cycle to the result cycle
  function automatic int ref_lat(input logic [XLEN-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int top = -1;
    for (int i = 0; i < XLEN; i++) if (b[i]) top = i;
    return b == '0 ? 1 : top + 2;
`else
    return b === b ? XLEN + 1 : 0;
`endif
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step_cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic brn, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    EX_valid = v;
    EX_brn = brn;
    EX_alu_op = op;
    EX_a = a;
    EX_b = b;
  endtask
  task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] p);
    int k = 0, sc = 0, bc = 0, lat = ref_lat(b);
    logic got = 0;
    drive(1, 0, OP_MUL, a, b);
    while (!got && k <= XLEN + 4) begin
      @(negedge clk);
      sc += int'(EX_stall);
      bc += int'(mul_busy);
      if (EX_mul_valid) got = 1;
      else begin
        step_cyc();
        k++;
      end
    end
    check("valid_cycle", 64'(k), 64'(lat));
    check("result", 64'(EX_mul_out), 64'(p));
    check("stall_cycles", 64'(sc), 64'(lat));
    check("busy_cycles", 64'(bc), 64'(lat));
    step_cyc();
  endtask
  task automatic settle(input logic [XLEN-1:0] held);
    drive(0, 0, OP_ADD, '0, '0);
    @(negedge clk);
    check("idle_valid", 64'(EX_mul_valid), 0);
    check("idle_busy", 64'(mul_busy), 0);
    check("held_out", 64'(EX_mul_out), 64'(held));
    step_cyc();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[8];
    logic [XLEN-1:0] ra, rb;
    int vp;
    tbl = '{'{32'd3, 32'd5, 32'd15},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
            '{32'd7, 32'd3, 32'd21},
            '{32'd9, 32'd0, 32'd0},
            '{32'h8000_0000, 32'd2, 32'd0},
            '{32'h0001_0000, 32'h0001_0000, 32'd0},
            '{32'd1234, 32'd5678, 32'd7006652},
            '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000}};
    drive(1, 0, OP_MUL, 32'd3, 32'd5);
    @(negedge clk);
    check("reset_outs", 64'({EX_stall, EX_mul_valid, mul_busy, EX_mul_out}), 0);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 0, OP_ADD, '0, '0);
    rst_n = 1;
    step_cyc();
    foreach (tbl[i]) begin
      run_mul(tbl[i].a, tbl[i].b, tbl[i].p);
      settle(tbl[i].p);
    end
    drive(1, 1, OP_MUL, 32'd3, 32'd5);
    @(negedge clk);
    check("brn_stall", 64'(EX_stall), 0);
    step_cyc();
    @(negedge clk);
    check("brn_busy", 64'(mul_busy), 0);
    drive(1, 0, OP_ADD, 32'd3, 32'd5);
    @(negedge clk);
    check("add_stall", 64'(EX_stall), 0);
    step_cyc();
    drive(1, 0, OP_MUL, 32'd3, 32'd5);
    EX_flush = 1;
    @(negedge clk);
    check("idle_flush_stall", 64'(EX_stall), 0);
    step_cyc();
    EX_flush = 0;
    drive(0, 0, OP_ADD, '0, '0);
    @(negedge clk);
    check("idle_flush_busy", 64'(mul_busy), 0);
    step_cyc();
    run_mul(32'd6, 32'd7, 32'd42);
    run_mul(32'd8, 32'd9, 32'd72);
    settle(32'd72);
    drive(1, 0, OP_MUL, 32'd1234, 32'd5678);
    repeat (10) step_cyc();
    EX_flush = 1;
    @(negedge clk);
    check("flush_stall", 64'(EX_stall), 0);
    check("flush_valid", 64'(EX_mul_valid), 0);
    step_cyc();
    EX_flush = 0;
    drive(0, 0, OP_ADD, '0, '0);
    @(negedge clk);
    check("flush_idle", 64'(mul_busy), 0);
    vp = 0;
    repeat (40) begin
      @(negedge clk);
      vp += int'(EX_mul_valid);
    end
    check("flush_no_valid", 64'(vp), 0);
    step_cyc();
    drive(1, 0, OP_MUL, 32'd3, 32'd5);
    repeat (ref_lat(32'd5)) step_cyc();
    EX_flush = 1;
    @(negedge clk);
    check("done_flush_busy", 64'(mul_busy), 1);
    check("done_flush_valid", 64'(EX_mul_valid), 0);
    check("done_flush_stall", 64'(EX_stall), 0);
    step_cyc();
    EX_flush = 0;
    drive(0, 0, OP_ADD, '0, '0);
    @(negedge clk);
    check("done_flush_idle", 64'(mul_busy), 0);
    step_cyc();
    drive(1, 0, OP_MUL, 32'hFFFF, 32'hFFFF);
    repeat (5) step_cyc();
    rst_n = 0;
    #1;
    check("midrun_reset_outs", 64'({EX_stall, EX_mul_valid, mul_busy, EX_mul_out}), 0);
    repeat (2) step_cyc();
    rst_n = 1;
    run_mul(32'hFFFF, 32'hFFFF, 32'hFFFE_0001);
    settle(32'hFFFE_0001);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(31, 0);
      run_mul(ra, rb, ref_mul(ra, rb));
      settle(ref_mul(ra, rb));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
